tp84_sndcmd_tx: RTL and testbench

- CPU-board side of the sound-command link for Time Pilot '84.
- Queues command bytes written by the main CPU and drives them onto cpubrd_Dout.
- Generates the sound_data latch strobe and then the sound_on interrupt strobe, each a falling-edge event, with timing wide enough for the sound board's 3-stage synchroniser at 14.31818 MHz.
- Sits between the main CPU bus decode and the sound board's cpubrd_Din / sound_data / sound_on inputs.

---
 rtl/tp84_snd_pkg.sv | 25 ++
 rtl/tp84_cmd_fifo.sv | 57 +++++
 rtl/tp84_sndcmd_tx.sv | 141 ++++++++++++++
 tb/tb_tp84_sndcmd_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tp84_snd_pkg.sv
// Shared types and default timing for the Time Pilot '84 sound-command link.
package tp84_snd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_IRQ,
    ST_GAP
  } tp84_sndtx_state_t;

  localparam int SNDTX_SETUP = 4;
  localparam int SNDTX_PULSE = 16;
  localparam int SNDTX_GAP   = 4096;

  localparam logic STROBE_IDLE = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tp84_cmd_fifo.sv
// Synchronous command FIFO: power-of-2 depth, pointers wrap naturally,
// fullness and emptiness are judged on the state before this cycle's push/pop.
module tp84_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_49m,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // NOTE: storage has no reset; occupancy is tracked by r_level, so stale
  // contents are never observed and the array can map to plain registers/RAM.
  always_ff @(posedge clk_49m) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/tp84_sndcmd_tx.sv
// CPU-board side of the TP84 sound link: queues command bytes and sequences
// the sound_data latch strobe followed by the sound_on IRQ strobe.
module tp84_sndcmd_tx
  import tp84_snd_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = SNDTX_SETUP,
  parameter int PULSE_CYC = SNDTX_PULSE,
  parameter int GAP_CYC   = SNDTX_GAP
) (
  input  logic                     clk_49m,
  input  logic                     reset,
  input  logic                     cmd_wr,
  input  logic [7:0]               cmd_data,
  output logic                     cmd_full,
  output logic [$clog2(DEPTH):0]   cmd_level,
  output logic                     busy,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [7:0]               cpubrd_Dout,
  output logic                     sound_data,
  output logic                     sound_on
);

  localparam int CW = $clog2(max3(GAP_CYC, PULSE_CYC, SETUP_CYC)) + 1;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

  tp84_sndtx_state_t r_state, w_state_n;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic              r_sd, w_sd_n;
  logic              r_so, w_so_n;
  logic [7:0]        r_dout;
  logic              r_ovf;
  logic              w_zero;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [7:0]        w_head;

  tp84_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_49m     (clk_49m),
    .reset       (reset),
    .i_push      (cmd_wr),
    .i_push_data (cmd_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (cmd_level)
  );

  assign w_zero      = (r_cnt == '0);
  assign cmd_full    = w_full;
  assign busy        = (r_state != ST_IDLE);
  assign overflow    = r_ovf;
  assign cpubrd_Dout = r_dout;
  assign sound_data  = r_sd;
  assign sound_on    = r_so;

  // NOTE: blocking assignments here describe combinational logic; every
  // output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_zero ? r_cnt : r_cnt - 1'b1;
    w_sd_n    = r_sd;
    w_so_n    = r_so;
    w_pop     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_cnt_n   = SETUP_LD;
          w_state_n = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_zero) begin
          w_sd_n    = ~STROBE_IDLE;
          w_cnt_n   = PULSE_LD;
          w_state_n = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (w_zero) begin
          w_sd_n    = STROBE_IDLE;
          w_cnt_n   = PULSE_LD;
          w_state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Byte stays on the bus so the receiver's late, synchronised latch
        // edge still samples it.
        if (w_zero) begin
          w_so_n    = ~STROBE_IDLE;
          w_cnt_n   = PULSE_LD;
          w_state_n = ST_IRQ;
        end
      end
      ST_IRQ: begin
        if (w_zero) begin
          w_so_n    = STROBE_IDLE;
          w_cnt_n   = GAP_LD;
          w_state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_zero) w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
        w_sd_n    = STROBE_IDLE;
        w_so_n    = STROBE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sd    <= STROBE_IDLE;
      r_so    <= STROBE_IDLE;
      r_dout  <= 8'h00;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_sd    <= w_sd_n;
      r_so    <= w_so_n;
      if (w_pop) r_dout <= w_head;
      // A dropped write wins over a simultaneous clear.
      r_ovf   <= (cmd_wr & w_full) | (r_ovf & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_tp84_sndcmd_tx.sv
// Directed bench for tp84_sndcmd_tx with a 14.31818 MHz 3-flop receiver model.
`timescale 1ns/1ps
module tb_tp84_sndcmd_tx;

  logic clk_49m = 1'b0;
  logic clk_rx  = 1'b0;
  logic reset   = 1'b0;
  always #10.1725 clk_49m = ~clk_49m;
  always #34.92   clk_rx  = ~clk_rx;

  // Default-parameter instance
  logic       cmd_wr = 1'b0, ovf_clr = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_full, busy, overflow, sound_data, sound_on;
  logic [2:0] cmd_level;
  logic [7:0] cpubrd_Dout;

  tp84_sndcmd_tx dut (
    .clk_49m(clk_49m), .reset(reset), .cmd_wr(cmd_wr), .cmd_data(cmd_data),
    .cmd_full(cmd_full), .cmd_level(cmd_level), .busy(busy), .overflow(overflow),
    .ovf_clr(ovf_clr), .cpubrd_Dout(cpubrd_Dout), .sound_data(sound_data),
    .sound_on(sound_on)
  );

  // Short-timing instance
  logic       cmd_wr_b = 1'b0, ovf_clr_b = 1'b0;
  logic [7:0] cmd_data_b = 8'h00;
  logic       cmd_full_b, busy_b, overflow_b, sound_data_b, sound_on_b;
  logic [2:0] cmd_level_b;
  logic [7:0] cpubrd_Dout_b;

  tp84_sndcmd_tx #(.DEPTH(4), .SETUP_CYC(4), .PULSE_CYC(12), .GAP_CYC(64)) dut_b (
    .clk_49m(clk_49m), .reset(reset), .cmd_wr(cmd_wr_b), .cmd_data(cmd_data_b),
    .cmd_full(cmd_full_b), .cmd_level(cmd_level_b), .busy(busy_b), .overflow(overflow_b),
    .ovf_clr(ovf_clr_b), .cpubrd_Dout(cpubrd_Dout_b), .sound_data(sound_data_b),
    .sound_on(sound_on_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_49m) cyc <= cyc + 1;

  // Sound-board receiver models: 3-flop synchronisers on each strobe
  logic [2:0] sd_s0 = 3'b111, so_s0 = 3'b111, sd_s1 = 3'b111, so_s1 = 3'b111;
  logic [7:0] lat0 = 8'h00, lat1 = 8'h00;
  logic [7:0] rx_q0[$];
  logic [7:0] rx_q1[$];
  int         rx_t0[$];

  always @(posedge clk_rx) begin
    sd_s0 <= {sd_s0[1:0], sound_data};
    so_s0 <= {so_s0[1:0], sound_on};
    sd_s1 <= {sd_s1[1:0], sound_data_b};
    so_s1 <= {so_s1[1:0], sound_on_b};
    if (sd_s0[2] && !sd_s0[1]) lat0 <= cpubrd_Dout;
    if (so_s0[2] && !so_s0[1]) begin
      rx_q0.push_back(lat0);
      rx_t0.push_back(cyc);
    end
    if (sd_s1[2] && !sd_s1[1]) lat1 <= cpubrd_Dout_b;
    if (so_s1[2] && !so_s1[1]) rx_q1.push_back(lat1);
  end

  bit both_low = 1'b0;
  always @(negedge clk_49m) begin
    if (!sound_data && !sound_on)     both_low = 1'b1;
    if (!sound_data_b && !sound_on_b) both_low = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_49m);
  endtask

  task automatic write1(input logic [7:0] d);
    cmd_data = d;
    cmd_wr   = 1'b1;
    @(negedge clk_49m);
    cmd_wr   = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int n = 0;
    while ((busy || cmd_level != 3'd0) && n < lim) begin
      @(negedge clk_49m);
      n++;
    end
    check(tag, (n < lim), 1);
  endtask

  logic [7:0] exp_b[$];

  initial begin
    int n, k;
    logic [7:0] dout_prev;
    logic [7:0] d;

    // ---- Reset with writes attempted ----
    step(2);
    cmd_data = 8'hEE;
    cmd_wr   = 1'b1;
    step(2);
    cmd_wr   = 1'b0;
    check("rst_sound_data", sound_data, 1);
    check("rst_sound_on", sound_on, 1);
    check("rst_dout", cpubrd_Dout, 8'h00);
    check("rst_level", cmd_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_full", cmd_full, 0);
    reset = 1'b1;
    step(3);

    // ---- Single command 5A ----
    cmd_data  = 8'h5A;
    cmd_wr    = 1'b1;
    n         = 0;
    dout_prev = cpubrd_Dout;
    do begin
      dout_prev = cpubrd_Dout;
      @(negedge clk_49m);
      cmd_wr = 1'b0;
      n++;
    end while (sound_data && n < 40);
    check("single_latency", n, 6);
    check("single_dout_before_fall", dout_prev, 8'h5A);
    k = 0;
    while (!sound_data && k < 100) begin step(1); k++; end
    check("single_sd_low", k, 16);
    k = 0;
    while (sound_on && k < 100) begin step(1); k++; end
    check("single_hold", k, 16);
    k = 0;
    while (!sound_on && k < 100) begin step(1); k++; end
    check("single_so_low", k, 16);
    k = 0;
    while (busy && k < 5000) begin step(1); k++; end
    check("single_gap", k, 4096);
    check("single_rx_count", rx_q0.size(), 1);
    if (rx_q0.size() > 0) check("single_rx_byte", rx_q0[0], 8'h5A);
    check("single_dout_hold", cpubrd_Dout, 8'h5A);
    rx_q0.delete();
    rx_t0.delete();

    // ---- Queueing 11,22,33,44 ----
    k = 0;
    for (int i = 0; i < 4; i++) begin
      cmd_data = 8'h11 * (i + 1);
      cmd_wr   = 1'b1;
      @(negedge clk_49m);
      if (int'(cmd_level) > k) k = int'(cmd_level);
    end
    cmd_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_49m);
      if (int'(cmd_level) > k) k = int'(cmd_level);
    end
    check("queue_peak_level", k, 3);
    wait_idle(4 * 4149 + 500, "queue_drain_timeout");
    check("queue_rx_count", rx_q0.size(), 4);
    if (rx_q0.size() == 4) begin
      for (int i = 0; i < 4; i++) check("queue_rx_byte", rx_q0[i], 8'h11 * (i + 1));
      for (int i = 1; i < 4; i++) check("queue_rx_gap", (rx_t0[i] - rx_t0[i-1] >= 4096), 1);
    end
    rx_q0.delete();
    rx_t0.delete();

    // ---- Overflow while stalled in GAP ----
    write1(8'h77);
    k = 0;
    while (sound_on && k < 100) begin step(1); k++; end
    k = 0;
    while (!sound_on && k < 40) begin step(1); k++; end
    check("ovf_reach_gap", busy, 1);
    for (int i = 0; i < 5; i++) begin
      cmd_data = 8'h81 + 8'(i);
      cmd_wr   = 1'b1;
      @(negedge clk_49m);
      if (i == 3) begin
        check("ovf_full_at_4", cmd_full, 1);
        check("ovf_clear_at_4", overflow, 0);
      end
    end
    cmd_wr = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_level", cmd_level, 4);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    ovf_clr  = 1'b1;
    cmd_wr   = 1'b1;
    cmd_data = 8'h90;
    step(1);
    ovf_clr  = 1'b0;
    cmd_wr   = 1'b0;
    check("ovf_clr_vs_drop", overflow, 1);
    check("ovf_level_after_drop", cmd_level, 4);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_clr2", overflow, 0);
    // write on the IDLE cycle that pops a full FIFO must still be dropped
    k = 0;
    while (busy && k < 4200) begin step(1); k++; end
    check("ovf_gap_end", busy, 0);
    write1(8'h99);
    check("ovf_drop_with_pop", overflow, 1);
    check("ovf_level_after_pop", cmd_level, 3);
    check("ovf_busy_after_pop", busy, 1);
    check("ovf_rx_count", rx_q0.size(), 1);
    if (rx_q0.size() > 0) check("ovf_rx_byte", rx_q0[0], 8'h77);

    // ---- Reset in the middle of STROBE ----
    k = 0;
    while (sound_data && k < 20) begin step(1); k++; end
    check("mid_strobe_reached", sound_data, 0);
    step(3);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_sound_data", sound_data, 1);
    check("mid_rst_sound_on", sound_on, 1);
    check("mid_rst_level", cmd_level, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dout", cpubrd_Dout, 8'h00);
    check("mid_rst_overflow", overflow, 0);
    step(2);
    reset = 1'b1;
    rx_q0.delete();
    rx_t0.delete();
    step(2);
    write1(8'hA5);
    wait_idle(4300, "post_rst_timeout");
    check("post_rst_rx_count", rx_q0.size(), 1);
    if (rx_q0.size() > 0) check("post_rst_rx_byte", rx_q0[0], 8'hA5);

    // ---- Short timing: 32-command random burst ----
    for (int i = 0; i < 32; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_b.push_back(d);
      k = 0;
      while (cmd_full_b && k < 300) begin step(1); k++; end
      cmd_data_b = d;
      cmd_wr_b   = 1'b1;
      step(1);
      cmd_wr_b   = 1'b0;
    end
    k = 0;
    while ((busy_b || cmd_level_b != 3'd0) && k < 5000) begin step(1); k++; end
    check("sweep_drain_timeout", (k < 5000), 1);
    step(20);
    check("sweep_overflow", overflow_b, 0);
    check("sweep_rx_count", rx_q1.size(), 32);
    if (rx_q1.size() == 32)
      for (int i = 0; i < 32; i++) check("sweep_rx_byte", rx_q1[i], exp_b[i]);

    check("never_both_low", both_low, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
